// File: rtl/inst_fetch_pkg.sv
// Shared types for the instruction fetch slice: FSM state encoding, the
// fetch entry carried through the output stage, and the instruction size.
package inst_fetch_pkg;

    localparam int unsigned INST_BYTES = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/inst_fetch_if.sv
// Fetch-side bus: instruction memory address/data, redirect request and the
// valid/ready instruction output. master = fetch unit, slave = environment.
interface inst_fetch_if;
    logic [31:0] out_m5;
    logic [31:0] out_m2;
    logic [31:0] inst_in;
    logic        redirect;
    logic [31:0] redirect_base;
    logic [31:0] redirect_off;
    logic        inst_ready;
    logic        inst_valid;
    logic [31:0] inst_out;
    logic [31:0] pc_out;

    modport master (
        output out_m5, out_m2, inst_valid, inst_out, pc_out,
        input  inst_in, redirect, redirect_base, redirect_off, inst_ready
    );

    modport slave (
        input  out_m5, out_m2, inst_valid, inst_out, pc_out,
        output inst_in, redirect, redirect_base, redirect_off, inst_ready
    );
endinterface

// File: rtl/inst_fetch_skid.sv
// fetch_skid: one-entry valid/ready skid buffer in front of the registered
// fetch output. o_full_next tells the issuer whether the skid will be occupied.
module fetch_skid
    import inst_fetch_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         i_flush,
    input  fetch_entry_t i_in,
    input  logic         i_out_ready,
    output fetch_entry_t o_out,
    output logic         o_full_next
);
    fetch_entry_t r_out;
    fetch_entry_t r_skid;
    logic         w_out_free;

    assign w_out_free  = !r_out.valid || i_out_ready;
    assign o_full_next = !i_flush &&
                         (w_out_free ? (r_skid.valid && i_in.valid)
                                     : (r_skid.valid || i_in.valid));
    assign o_out       = r_out;

    // The issuer never pushes into a full skid while the output is blocked.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out  <= '0;
            r_skid <= '0;
        end else if (i_flush) begin
            r_out  <= '0;
            r_skid <= '0;
        end else if (w_out_free) begin
            if (r_skid.valid) begin
                r_out  <= r_skid;
                r_skid <= i_in.valid ? i_in : '0;
            end else begin
                r_out  <= i_in.valid ? i_in : '0;
            end
        end else if (i_in.valid) begin
            r_skid <= i_in;
        end
    end
endmodule

// File: rtl/inst_fetch.sv
// inst_fetch: sequential PC generator with one-cycle memory, in-flight tag,
// skid-buffered output and redirect. Optional INST_FETCH_MISALIGN_CHK_EN adds fetch_fault.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter int unsigned IMEM_BYTES = 128,
    parameter logic [31:0] RESET_PC   = 32'h0
) (
    input  logic         clk,
    input  logic         reset,
    inst_fetch_if.master bus
`ifdef INST_FETCH_MISALIGN_CHK_EN
    ,
    output logic         fetch_fault
`endif
);
    localparam logic [1:0]  S_IDLE   = ST_IDLE;
    localparam logic [1:0]  S_RUN    = ST_RUN;
    localparam logic [1:0]  S_HOLD   = ST_HOLD;
    localparam logic [31:0] PC_MASK  = 32'(IMEM_BYTES - 1);
    localparam logic [31:0] ALN_MASK = ~32'(INST_BYTES - 1);

    logic [1:0]   r_state;
    logic [31:0]  r_pc;
    logic         r_if_vld;
    logic [31:0]  r_if_pc;

    logic [31:0]  w_target_raw;
    logic [31:0]  w_target;
    logic [31:0]  w_pc_inc;
    logic         w_full_next;
    logic         w_issue;
    fetch_entry_t w_push;
    fetch_entry_t w_out;

    assign w_target_raw = bus.redirect_base + bus.redirect_off;
    assign w_target     = w_target_raw & PC_MASK & ALN_MASK;
    assign w_pc_inc     = (r_pc + 32'(INST_BYTES)) & PC_MASK;

    // Issue only when the returning word is guaranteed a slot; this also lets
    // the HOLD->RUN cycle issue so the stream resumes without a bubble.
    assign w_issue = (r_state != S_IDLE) && !w_full_next && !bus.redirect;

    assign w_push = '{valid: r_if_vld, pc: r_if_pc, inst: bus.inst_in};

    fetch_skid u_skid (
        .clk         (clk),
        .rst         (reset),
        .i_flush     (bus.redirect),
        .i_in        (w_push),
        .i_out_ready (bus.inst_ready),
        .o_out       (w_out),
        .o_full_next (w_full_next)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_pc     <= RESET_PC;
            r_if_vld <= 1'b0;
            r_if_pc  <= '0;
        end else if (bus.redirect) begin
            r_state  <= S_RUN;
            r_pc     <= w_target;
            r_if_vld <= 1'b0;
        end else begin
            r_state  <= (r_state == S_IDLE) ? S_RUN : (w_full_next ? S_HOLD : S_RUN);
            r_if_vld <= w_issue;
            if (w_issue) begin
                r_if_pc <= r_pc;
                r_pc    <= w_pc_inc;
            end
        end
    end

`ifdef INST_FETCH_MISALIGN_CHK_EN
    logic r_fault;
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_fault <= 1'b0;
        else if (bus.redirect && (w_target_raw[1:0] != 2'b00))
            r_fault <= 1'b1;
    end
    assign fetch_fault = r_fault;
`endif

    assign bus.out_m5     = r_pc;
    assign bus.out_m2     = '0;
    assign bus.inst_valid = w_out.valid;
    assign bus.inst_out   = w_out.inst;
    assign bus.pc_out     = w_out.pc;
endmodule

// File: tb/tb_inst_fetch.sv
// Scoreboard bench for inst_fetch: 32-word memory model, expected (pc, inst)
// queue restarted on reset/redirect, popped on every output transfer.
module tb_inst_fetch;
    localparam int unsigned IMEM = 128;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
`ifdef INST_FETCH_MISALIGN_CHK_EN
    logic fetch_fault;
`endif

    inst_fetch_if bus ();

    inst_fetch #(.IMEM_BYTES(IMEM), .RESET_PC(32'h0)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef INST_FETCH_MISALIGN_CHK_EN
        ,
        .fetch_fault (fetch_fault)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_at(input logic [31:0] pc);
        return 32'hA500_0000 + (pc >> 2) * 32'h0001_0003;
    endfunction

    logic [31:0] mem [32];
    initial for (int i = 0; i < 32; i++) mem[i] = word_at(32'(i * 4));
    always @(posedge clk) bus.inst_in <= mem[bus.out_m5[6:2]];

    int          n_chk  = 0;
    int          n_pass = 0;
    exp_t        sb[$];
    logic [31:0] model_pc;
    logic        held = 1'b0;
    logic [31:0] held_pc, held_inst;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", tag, got, exp);
    endtask

    task automatic sb_push_next();
        exp_t e;
        e.pc   = model_pc;
        e.inst = word_at(model_pc);
        sb.push_back(e);
        model_pc = (model_pc + 32'd4) % IMEM;
    endtask

    task automatic sb_restart(input logic [31:0] pc);
        sb.delete();
        model_pc = pc;
        held     = 1'b0;
        sb_push_next();
    endtask

    // One cycle: monitor at negedge, then return just after the next posedge.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (held) begin
            chk("hold_valid", 32'(bus.inst_valid), 32'd1);
            chk("hold_pc", bus.pc_out, held_pc);
            chk("hold_inst", bus.inst_out, held_inst);
        end
        if (bus.inst_valid && bus.inst_ready) begin
            e = sb.pop_front();
            chk("sb_pc", bus.pc_out, e.pc);
            chk("sb_inst", bus.inst_out, e.inst);
            sb_push_next();
        end
        held      = bus.inst_valid && !bus.inst_ready;
        held_pc   = bus.pc_out;
        held_inst = bus.inst_out;
        @(posedge clk);
        #1;
    endtask

    task automatic do_redirect(input logic [31:0] base, input logic [31:0] off);
        logic [31:0] tgt;
        tgt               = ((base + off) % IMEM) & ~32'd3;
        bus.redirect      = 1'b1;
        bus.redirect_base = base;
        bus.redirect_off  = off;
        tick();
        bus.redirect = 1'b0;
        sb_restart(tgt);
        chk("rd_clear", 32'(bus.inst_valid), 32'd0);
        tick();
        chk("rd_lat1", 32'(bus.inst_valid), 32'd0);
        tick();
        chk("rd_lat2", 32'(bus.inst_valid), 32'd1);
        chk("rd_target", bus.pc_out, tgt);
    endtask

    initial begin
        logic [31:0] m5_saved;
        bit          found;
        reset             = 1'b1;
        bus.inst_ready    = 1'b1;
        bus.redirect      = 1'b0;
        bus.redirect_base = '0;
        bus.redirect_off  = '0;
        sb_restart(32'h0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_m5", bus.out_m5, 32'h0);
        chk("rst_m2", bus.out_m2, 32'h0);
        chk("rst_valid", 32'(bus.inst_valid), 32'd0);
        chk("rst_inst", bus.inst_out, 32'h0);
        chk("rst_pcout", bus.pc_out, 32'h0);
`ifdef INST_FETCH_MISALIGN_CHK_EN
        chk("rst_fault", 32'(fetch_fault), 32'd0);
`endif
        reset = 1'b0;

        // Stream to 0x10, then stall the consumer for five cycles.
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            found = bus.inst_valid && (bus.pc_out == 32'h10);
        end
        chk("reach_0x10", 32'(found), 32'd1);
        bus.inst_ready = 1'b0;
        tick();
        m5_saved = bus.out_m5;
        repeat (4) tick();
        chk("frozen_m5", bus.out_m5, m5_saved);
        chk("held_at_0x10", bus.pc_out, 32'h10);
        bus.inst_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("no_gap", 32'(bus.inst_valid), 32'd1);
        end

        // Long stream covers the 124 -> 0 wrap, then a random-stall phase.
        repeat (40) tick();
        for (int i = 0; i < 150; i++) begin
            bus.inst_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        bus.inst_ready = 1'b1;
        repeat (3) tick();

        do_redirect(32'h20, 32'h08);
        repeat (5) tick();

        // Redirect while HOLD with a full skid.
        bus.inst_ready = 1'b0;
        repeat (4) tick();
        do_redirect(32'h40, 32'h0C);
        repeat (2) tick();
        bus.inst_ready = 1'b1;
        repeat (5) tick();

        do_redirect(32'hFFFF_FFF0, 32'h30);
        repeat (4) tick();
        do_redirect(32'h100, 32'h14);
        repeat (4) tick();
        do_redirect(32'h7C, 32'h0);
        repeat (4) tick();

        // Asynchronous reset mid-stream, then a redirect in the IDLE cycle.
        reset = 1'b1;
        #1;
        chk("async_valid", 32'(bus.inst_valid), 32'd0);
        chk("async_m5", bus.out_m5, 32'h0);
        sb_restart(32'h0);
        tick();
        tick();
        reset = 1'b0;
        do_redirect(32'h30, 32'h0);
        repeat (6) tick();

        reset = 1'b1;
        tick();
        reset = 1'b0;
        sb_restart(32'h0);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            tick();
            found = bus.inst_valid;
        end
        chk("restart_valid", 32'(found), 32'd1);
        chk("restart_pc", bus.pc_out, 32'h0);
        repeat (4) tick();

        do_redirect(32'h08, 32'h02);
`ifdef INST_FETCH_MISALIGN_CHK_EN
        chk("fault_set", 32'(fetch_fault), 32'd1);
        repeat (5) tick();
        chk("fault_sticky", 32'(fetch_fault), 32'd1);
        reset = 1'b1;
        #1;
        chk("fault_clear", 32'(fetch_fault), 32'd0);
        reset = 1'b0;
`else
        repeat (5) tick();
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
